// File: rtl/dkong_rom_arbiter.sv
// dkong_rom_arbiter: shares the single sound-sample ROM port among three
// requesters (walk/jump wave, background music, spare/roar). Grants one read
// at a time, waits ROM_LAT clocks, then returns the byte with a one-cycle ack.
// Optional macro DKONG_ARB_RR_EN: round-robin arbitration instead of the
// default fixed priority 0 > 1 > 2.
module dkong_rom_arbiter #(
    parameter int ROM_LAT = 2,   // 1..15
    parameter int N_REQ   = 3
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic [N_REQ-1:0]     I_REQ,
    input  logic [19*N_REQ-1:0]  I_AB,
    output logic [N_REQ-1:0]     O_ACK,
    output logic [7:0]           O_DB,
    output logic                 O_BUSY,
    output logic [18:0]          O_ROM_AB,
    input  logic [7:0]           I_ROM_DB
);

    typedef enum logic {IDLE, WAIT} state_t;

    // lat_cnt counts down to the capture edge; ROM_LAT=1 starts at zero
    localparam logic [3:0] LAT_INIT = 4'(ROM_LAT - 1);

    state_t                  state;
    logic [1:0]              grant;
    logic [1:0]              last_grant;
    logic [3:0]              lat_cnt;
    logic [1:0]              win;
    logic                    win_vld;
    logic [N_REQ-1:0][18:0]  req_ab;

    assign req_ab = I_AB;

`ifdef DKONG_ARB_RR_EN
    int   rr_idx;
    logic rr_found;

    // round-robin: search starts just after the last served requester
    always_comb begin
        win      = '0;
        win_vld  = |I_REQ;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = (int'(last_grant) + 1 + k) % N_REQ;
            if (!rr_found && I_REQ[rr_idx]) begin
                win      = 2'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end
`else
    // last_grant is tracked in this build but never steers selection
    logic lg_unused;
    assign lg_unused = ^last_grant;

    // fixed priority: lowest index wins
    always_comb begin
        win     = '0;
        win_vld = |I_REQ;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (I_REQ[i]) win = 2'(i);
    end
`endif

    // grant / latency wait / capture-and-ack sequencer
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state      <= IDLE;
            O_ACK      <= '0;
            O_DB       <= '0;
            O_ROM_AB   <= '0;
            O_BUSY     <= 1'b0;
            grant      <= '0;
            lat_cnt    <= '0;
            last_grant <= 2'd2;
        end else begin
            // ack is a single-cycle pulse
            O_ACK <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        O_ROM_AB <= req_ab[win];
                        grant    <= win;
                        lat_cnt  <= LAT_INIT;
                        O_BUSY   <= 1'b1;
                        state    <= WAIT;
                    end else begin
                        O_BUSY   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        // byte is always latched; ack only if still wanted
                        O_DB         <= I_ROM_DB;
                        O_ACK[grant] <= I_REQ[grant];
                        last_grant   <= grant;
                        O_BUSY       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dkong_rom_arbiter.sv
// Bench for dkong_rom_arbiter: directed steps plus randomized requesters,
// checked against a transaction-level reference model. Extra instances
// cover ROM_LAT=1 and ROM_LAT=15 ack timing.
module tb_dkong_rom_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [56:0] ab  = '0;
    logic [2:0]  ack;
    logic [7:0]  db;
    logic        busy;
    logic [18:0] rom_ab;
    logic [7:0]  rom_db;
    logic [7:0]  rom_q;

    // ROM_LAT=1 and ROM_LAT=15 instances
    logic [2:0]  req1 = '0, req15 = '0;
    logic [56:0] ab1  = '0, ab15  = '0;
    logic [2:0]  ack1, ack15;
    logic [7:0]  db1, db15;
    logic        busy1, busy15;
    logic [18:0] rom_ab1, rom_ab15;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h86;
    endfunction

    // ROM with one pipeline register: data valid LAT=2 edges after address
    always @(posedge clk) rom_q <= rom(rom_ab);
    assign rom_db = rom_q;

    dkong_rom_arbiter #(.ROM_LAT(LAT)) u_dut (
        .I_CLK(clk), .I_RST(rst), .I_REQ(req), .I_AB(ab), .O_ACK(ack),
        .O_DB(db), .O_BUSY(busy), .O_ROM_AB(rom_ab), .I_ROM_DB(rom_db));

    dkong_rom_arbiter #(.ROM_LAT(1)) u_lat1 (
        .I_CLK(clk), .I_RST(rst), .I_REQ(req1), .I_AB(ab1), .O_ACK(ack1),
        .O_DB(db1), .O_BUSY(busy1), .O_ROM_AB(rom_ab1), .I_ROM_DB(rom(rom_ab1)));

    dkong_rom_arbiter #(.ROM_LAT(15)) u_lat15 (
        .I_CLK(clk), .I_RST(rst), .I_REQ(req15), .I_AB(ab15), .O_ACK(ack15),
        .O_DB(db15), .O_BUSY(busy15), .O_ROM_AB(rom_ab15), .I_ROM_DB(rom(rom_ab15)));

    // reference model: one transaction record, completion scheduled by edge number
    int          edge_n = 0;
    logic        m_busy;
    int          m_done;
    int          m_g;
    int          m_last;
    logic [18:0] m_addr;
    logic [18:0] m_rom_ab;
    logic [7:0]  m_db;
    logic [2:0]  m_ack;

    task automatic model_reset();
        m_busy = 1'b0; m_done = 0; m_g = 0; m_last = 2;
        m_addr = '0; m_rom_ab = '0; m_db = '0; m_ack = '0;
    endtask

    function automatic int pick(input logic [2:0] r, input int last);
`ifdef DKONG_ARB_RR_EN
        for (int k = 0; k < 3; k++)
            if (r[(last + 1 + k) % 3]) return (last + 1 + k) % 3;
`else
        for (int k = 0; k < 3; k++)
            if (r[k]) return k;
`endif
        return last - last;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge, step the model, compare the main DUT
    task automatic tick();
        logic [2:0]  r;
        logic [56:0] a;
        r = req;
        a = ab;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_ack = '0;
            if (m_busy && edge_n == m_done) begin
                m_db = rom(m_addr);
                if (r[m_g]) m_ack[m_g] = 1'b1;
                m_last = m_g;
                m_busy = 1'b0;
            end else if (!m_busy && r != 3'b000) begin
                m_g      = pick(r, m_last);
                m_addr   = a[19*m_g +: 19];
                m_rom_ab = m_addr;
                m_done   = edge_n + LAT;
                m_busy   = 1'b1;
            end
        end
        edge_n++;
        #1;
        check("ack",    32'(ack),    32'(m_ack));
        check("db",     32'(db),     32'(m_db));
        check("busy",   32'(busy),   32'(m_busy));
        check("rom_ab", 32'(rom_ab), 32'(m_rom_ab));
    endtask

    initial begin
        model_reset();

        // reset state
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_ab", 32'(rom_ab), 32'd0);
        check("rst_db", 32'(db), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // single request, address 19'h10123 -> byte A5
        req = 3'b001;
        ab[18:0] = 19'h10123;
        tick();
        check("a_rom_ab", 32'(rom_ab), 32'h10123);
        check("a_busy_e0", 32'(busy), 32'd1);
        tick();
        check("a_ack_e1", 32'(ack), 32'd0);
        tick();
        check("a_ack_e2", 32'(ack), 32'b001);
        check("a_db", 32'(db), 32'hA5);
        req = 3'b000;
        tick();
        check("a_ack_e3", 32'(ack), 32'd0);

        // all three held continuously
        ab = {19'h4AAAA, 19'h25555, 19'h00777};
        req = 3'b111;
        for (int c = 0; c < 12; c++) tick();
        req = 3'b000;
        for (int c = 0; c < 3; c++) tick();

        // requester 1 granted then dropped at E1; requester 2 pending
        req = 3'b110;
        ab = {19'h7F00F, 19'h12345, 19'h0};
        tick();
        check("d_rom_ab", 32'(rom_ab), 32'h12345);
        req = 3'b100;
        tick();
        tick();
        check("d_no_ack", 32'(ack), 32'd0);
        check("d_db", 32'(db), 32'(rom(19'h12345)));
        check("d_busy_low", 32'(busy), 32'd0);
        tick();
        check("d_req2_grant", 32'(rom_ab), 32'h7F00F);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack != 3'b000) req = 3'b000;
        end
        tick();

        // async reset in the middle of a transaction
        req = 3'b001;
        ab[18:0] = 19'h3C3C3;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        check("r_ack", 32'(ack), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_rom_ab", 32'(rom_ab), 32'd0);
        check("r_db", 32'(db), 32'd0);
        req = 3'b000;
        tick();
        rst = 1'b0;
        req = 3'b010;
        ab[37:19] = 19'h0BEEF;
        for (int c = 0; c < 3; c++) tick();
        check("r_fresh_ack", 32'(ack), 32'b010);
        req = 3'b000;
        tick();

        // randomized requesters
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (ack[i]) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                    if (req[i]) ab[19*i +: 19] = 19'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        ab[19*i +: 19] = 19'($urandom);
                    end
                end else begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) ab[19*i +: 19] = 19'($urandom);
                end
            end
            tick();
        end
        req = 3'b000;
        for (int c = 0; c < 4; c++) tick();

        // ROM_LAT=1 and ROM_LAT=15 single requests: ack after edge E(LAT)
        req1 = 3'b010;  ab1[37:19]  = 19'h11111;
        req15 = 3'b010; ab15[37:19] = 19'h5A5A5;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0) begin
                check("l1_busy", 32'(busy1), 32'd1);
                check("l15_busy", 32'(busy15), 32'd1);
            end
            check($sformatf("l1_ack_k%0d", k), 32'(ack1), (k == 1) ? 32'b010 : 32'd0);
            check($sformatf("l15_ack_k%0d", k), 32'(ack15), (k == 15) ? 32'b010 : 32'd0);
            if (k == 1) begin
                check("l1_db", 32'(db1), 32'(rom(19'h11111)));
                req1 = 3'b000;
            end
            if (k == 15) begin
                check("l15_db", 32'(db15), 32'(rom(19'h5A5A5)));
                req15 = 3'b000;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
